// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - camera VSYNC/HREF byte stream to QVGA RGB565 frame buffer writer
//
// Ports:
//   clk         camera pixel clock, rising edge
//   reset_n     asynchronous active-low reset
//   cap_en      capture enable, sampled at frame start only
//   vsync       camera VSYNC, high = vertical blanking
//   href        camera HREF, high = valid byte on data
//   data        camera byte (first = RGB565[15:8], second = [7:0])
//   we          frame buffer write strobe, one cycle per pixel
//   wAddr       frame buffer write address (y*H_ACT+x)
//   wData       RGB565 pixel
//   frame_done  one-cycle pulse when a captured frame closes
//   overflow    sticky: frame exceeded H_ACT px/line or V_ACT lines
module cam_frame_capture #(
    parameter int H_ACT  = 320,
    parameter int V_ACT  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [9:0]        L_H  = 10'(H_ACT);
    localparam logic [9:0]        L_V  = 10'(V_ACT);
    localparam logic [ADDR_W-1:0] L_HA = ADDR_W'(H_ACT);

    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_vsync_d;
    logic              r_href_d;
    logic              r_armed;
    logic              r_phase;
    logic [7:0]        r_hi_byte;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [15:0]       r_wdata;
    logic              r_frame_done;
    logic              r_overflow;

    logic w_vs_fall;
    logic w_vs_rise;
    logic w_hr_fall;
    logic w_start;
    logic w_done;

    assign w_vs_fall = r_vsync_d & ~vsync;
    assign w_vs_rise = ~r_vsync_d & vsync;
    assign w_hr_fall = r_href_d & ~href;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_armed blocks the false falling edge that the reset value of
                // r_vsync_d would create when reset releases mid-frame, so a
                // partial frame is never picked up.
                if (w_vs_fall && cap_en && r_armed) begin
                    w_state_next = S_CAPTURE;
                    w_start      = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (w_vs_rise) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_vsync_d    <= 1'b1;
            r_href_d     <= 1'b0;
            r_armed      <= 1'b0;
            r_phase      <= 1'b0;
            r_hi_byte    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_row_base   <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_vsync_d    <= vsync;
            r_href_d     <= href;
            r_we         <= 1'b0;
            r_frame_done <= w_done;
            if (vsync) begin
                r_armed <= 1'b1;
            end
            if (w_start) begin
                r_phase    <= 1'b0;
                r_x        <= '0;
                r_y        <= '0;
                r_addr     <= '0;
                r_row_base <= '0;
                r_overflow <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (href) begin
                    if (!r_phase) begin
                        r_hi_byte <= data;
                        r_phase   <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_x < L_H && r_y < L_V) begin
                            r_we    <= 1'b1;
                            r_wdata <= {r_hi_byte, data};
                            r_waddr <= r_addr;
                            r_addr  <= r_addr + 1'b1;
                            r_x     <= r_x + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                            if (r_x < L_H) begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                end else if (w_hr_fall) begin
                    // Realign to the next row base so a short line does not
                    // shift every following line.
                    r_phase <= 1'b0;
                    r_x     <= '0;
                    if (r_y < L_V) begin
                        r_y        <= r_y + 1'b1;
                        r_row_base <= r_row_base + L_HA;
                        r_addr     <= r_row_base + L_HA;
                    end
                end
            end
        end
    end

    assign we         = r_we;
    assign wAddr      = r_waddr;
    assign wData      = r_wdata;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb/tb_cam_frame_capture.sv - directed self-checking bench for cam_frame_capture
module tb_cam_frame_capture;

    // Full 320-pixel lines; frame height reduced to keep the full-frame run short.
    localparam int TB_H = 320;
    localparam int TB_V = 20;
    localparam int AW   = 17;

    logic          clk;
    logic          reset_n;
    logic          cap_en;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          frame_done;
    logic          overflow;

    int n_tests;
    int n_fail;
    int fd_count;
    logic [AW-1:0] log_addr[$];
    logic [15:0]   log_data[$];

    cam_frame_capture #(.H_ACT(TB_H), .V_ACT(TB_V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_en     (cap_en),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            log_addr.push_back(wAddr);
            log_data.push_back(wData);
        end
        if (frame_done) fd_count++;
    end

    task automatic clr();
        log_addr.delete();
        log_data.delete();
        fd_count = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic frame_start(input logic en);
        @(negedge clk);
        href = 1'b0; vsync = 1'b1; cap_en = en;
        idle_cycles(3);
        vsync = 1'b0;
        idle_cycles(3);
    endtask

    task automatic frame_end();
        @(negedge clk);
        href = 1'b0; vsync = 1'b1;
        idle_cycles(4);
    endtask

    task automatic send_line(input int nbytes, input int base);
        for (int j = 0; j < nbytes; j++) begin
            @(negedge clk);
            href = 1'b1;
            data = 8'(base + j);
        end
        @(negedge clk);
        href = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vsync = i[0]; href = ~i[0]; data = 8'(i * 37); cap_en = 1'b1;
        end
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", we); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        n_tests++; if (wAddr !== '0) begin n_fail++; $display("FAIL reset_waddr got %0d exp 0", wAddr); end
        n_tests++; if (wData !== 16'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", wData); end
        @(negedge clk);
        vsync = 1'b1; href = 1'b0;
        reset_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single_pixel();
        clr();
        frame_start(1'b1);
        @(negedge clk); href = 1'b1; data = 8'hF8;
        @(negedge clk); data = 8'h1F;
        @(negedge clk); href = 1'b0;
        n_tests++; if (we !== 1'b1) begin n_fail++; $display("FAIL t2_we got %b exp 1", we); end
        n_tests++; if (wData !== 16'hF81F) begin n_fail++; $display("FAIL t2_wdata got %h exp f81f", wData); end
        n_tests++; if (wAddr !== 17'd0) begin n_fail++; $display("FAIL t2_waddr got %0d exp 0", wAddr); end
        @(negedge clk);
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL t2_we_pulse got %b exp 0", we); end
        frame_end();
        n_tests++; if (log_addr.size() !== 1) begin n_fail++; $display("FAIL t2_count got %0d exp 1", log_addr.size()); end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL t2_fd got %0d exp 1", fd_count); end
    endtask

    task automatic test_full_frame();
        int bad;
        clr();
        frame_start(1'b1);
        for (int y = 0; y < TB_V; y++) send_line(2 * TB_H, y * 2 * TB_H);
        frame_end();
        n_tests++; if (log_addr.size() !== TB_H * TB_V) begin n_fail++; $display("FAIL t3_count got %0d exp %0d", log_addr.size(), TB_H * TB_V); end
        n_tests++; if (log_addr.size() > 0 && log_addr[log_addr.size() - 1] !== AW'(TB_H * TB_V - 1)) begin
            n_fail++; $display("FAIL t3_last_addr got %0d exp %0d", log_addr[log_addr.size() - 1], TB_H * TB_V - 1);
        end
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== AW'(i) || log_data[i] !== {8'(2 * i), 8'(2 * i + 1)}) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL t3_pattern got %0d bad writes exp 0", bad); end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL t3_fd got %0d exp 1", fd_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t3_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_short_long_odd();
        clr();
        frame_start(1'b1);
        send_line(600, 0);
        send_line(660, 0);
        send_line(7, 0);
        send_line(2, 8'hAB);
        frame_end();
        n_tests++; if (log_addr.size() !== 624) begin n_fail++; $display("FAIL t4_count got %0d exp 624", log_addr.size()); end
        if (log_addr.size() == 624) begin
            n_tests++; if (log_addr[300] !== 17'd320) begin n_fail++; $display("FAIL t4_line1_first got %0d exp 320", log_addr[300]); end
            n_tests++; if (log_addr[619] !== 17'd639) begin n_fail++; $display("FAIL t4_line1_last got %0d exp 639", log_addr[619]); end
            n_tests++; if (log_addr[620] !== 17'd640) begin n_fail++; $display("FAIL t4_line2_first got %0d exp 640", log_addr[620]); end
            n_tests++; if (log_data[622] !== 16'h0405) begin n_fail++; $display("FAIL t4_odd_last got %h exp 0405", log_data[622]); end
            n_tests++; if (log_addr[623] !== 17'd960) begin n_fail++; $display("FAIL t4_line3_addr got %0d exp 960", log_addr[623]); end
            n_tests++; if (log_data[623] !== 16'hABAC) begin n_fail++; $display("FAIL t4_line3_data got %h exp abac", log_data[623]); end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf got %b exp 1", overflow); end
    endtask

    task automatic test_enable_gating();
        clr();
        frame_start(1'b0);
        send_line(8, 0);
        send_line(8, 0);
        frame_end();
        n_tests++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL t5_skip_count got %0d exp 0", log_addr.size()); end
        n_tests++; if (fd_count !== 0) begin n_fail++; $display("FAIL t5_skip_fd got %0d exp 0", fd_count); end
        clr();
        frame_start(1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t5_ovf_clear got %b exp 0", overflow); end
        send_line(8, 0);
        cap_en = 1'b0;
        send_line(8, 0);
        frame_end();
        n_tests++; if (log_addr.size() !== 8) begin n_fail++; $display("FAIL t5_mid_count got %0d exp 8", log_addr.size()); end
        n_tests++; if (log_addr.size() == 8 && log_addr[7] !== 17'd323) begin n_fail++; $display("FAIL t5_mid_last got %0d exp 323", log_addr[7]); end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL t5_mid_fd got %0d exp 1", fd_count); end
    endtask

    task automatic test_vs_rise_with_pixel();
        clr();
        frame_start(1'b1);
        @(negedge clk); href = 1'b1; data = 8'h12;
        @(negedge clk); data = 8'h34; vsync = 1'b1;
        @(negedge clk); href = 1'b0;
        n_tests++; if (we !== 1'b1 || frame_done !== 1'b1) begin n_fail++; $display("FAIL tvr_same_cycle got we=%b fd=%b exp 1 1", we, frame_done); end
        idle_cycles(3);
        n_tests++; if (log_data.size() !== 1 || log_data[0] !== 16'h1234) begin n_fail++; $display("FAIL tvr_write got n=%0d exp 1 write of 1234", log_data.size()); end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL tvr_fd got %0d exp 1", fd_count); end
    endtask

    task automatic test_reset_mid_frame();
        clr();
        frame_start(1'b1);
        for (int y = 0; y < 10; y++) send_line(8, y);
        @(negedge clk); href = 1'b1; data = 8'h55;
        @(negedge clk); data = 8'h66;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_tests++; if (we !== 1'b0 || wAddr !== '0 || wData !== 16'h0) begin n_fail++; $display("FAIL t6_async got we=%b addr=%0d data=%h exp 0 0 0", we, wAddr, wData); end
        idle_cycles(3);
        clr();
        href = 1'b0;
        reset_n = 1'b1;
        for (int y = 0; y < 3; y++) send_line(8, y);
        n_tests++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL t6_no_resume got %0d writes exp 0", log_addr.size()); end
        frame_end();
        n_tests++; if (fd_count !== 0) begin n_fail++; $display("FAIL t6_fd got %0d exp 0", fd_count); end
        frame_start(1'b1);
        send_line(8, 0);
        frame_end();
        n_tests++; if (log_addr.size() !== 4 || log_addr[0] !== 17'd0) begin n_fail++; $display("FAIL t6_restart got n=%0d exp 4 writes from addr 0", log_addr.size()); end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL t6_restart_fd got %0d exp 1", fd_count); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; fd_count = 0;
        reset_n = 1'b0; cap_en = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_short_long_odd();
        test_enable_gating();
        test_vs_rise_with_pixel();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
